// File: rtl/alu_muldiv_pkg.sv
// Shared opcode and FSM state encodings for the iterative multiply/divide unit.
package alu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MADDU = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration: shift-add multiply or restoring divide
// on unsigned magnitudes.
module muldiv_step #(
    parameter int B = 32
) (
    input  logic         is_div_i,
    input  logic [B:0]   part_i,
    input  logic         in_bit_i,
    input  logic [B-1:0] operand_i,
    output logic [B:0]   part_o,
    output logic         bit_o
);

    logic [B:0]   sum;
    logic [B:0]   shifted;
    logic [B+1:0] diff;

    always_comb begin
        sum     = part_i + ({(B+1){in_bit_i}} & {1'b0, operand_i});
        shifted = {part_i[B-1:0], in_bit_i};
        diff    = {1'b0, shifted} - {2'b00, operand_i};
        if (is_div_i) begin
            // A borrow out of diff means the divisor did not fit: restore.
            bit_o  = ~diff[B+1];
            part_o = diff[B+1] ? shifted : diff[B:0];
        end else begin
            bit_o  = sum[0];
            part_o = {1'b0, sum[B:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO pair.
// Define ALU_MULDIV_MADD_EN to enable MADD/MADDU accumulation into {hi,lo}.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [B-1:0] op1,
    input  logic [B-1:0] op2,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [B-1:0] hi,
    output logic [B-1:0] lo
);

    localparam int CNT_W = $clog2(B) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [B:0]       part_q, part_d;
    logic [B-1:0]     low_q, low_d;
    logic [B-1:0]     opnd_q, opnd_d;
    logic [B-1:0]     hi_q, hi_d;
    logic [B-1:0]     lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
`ifdef ALU_MULDIV_MADD_EN
    logic             madd_q, madd_d;
`endif

    op_e            op_s;
    logic           is_mul_op, is_div_op, is_signed_op, is_madd_op;
    logic           a_neg, b_neg;
    logic [B-1:0]   a_mag, b_mag;
    logic [B:0]     step_part;
    logic           step_bit;
    logic [2*B-1:0] prod_mag, prod_s;
    logic [B-1:0]   quo_s, rem_s;

    assign op_s = op_e'(op);

    always_comb begin
        is_madd_op = 1'b0;
`ifdef ALU_MULDIV_MADD_EN
        is_madd_op = (op_s == OP_MADD) || (op_s == OP_MADDU);
`endif
        is_div_op    = (op_s == OP_DIV) || (op_s == OP_DIVU);
        is_mul_op    = (op_s == OP_MULT) || (op_s == OP_MULTU) || is_madd_op;
        is_signed_op = (op_s == OP_MULT) || (op_s == OP_DIV) || (op_s == OP_MADD);
        a_neg        = is_signed_op & op1[B-1];
        b_neg        = is_signed_op & op2[B-1];
        a_mag        = a_neg ? -op1 : op1;
        b_mag        = b_neg ? -op2 : op2;
    end

    muldiv_step #(.B(B)) u_step (
        .is_div_i  (is_div_q),
        .part_i    (part_q),
        .in_bit_i  (is_div_q ? low_q[B-1] : low_q[0]),
        .operand_i (opnd_q),
        .part_o    (step_part),
        .bit_o     (step_bit)
    );

    // Iteration runs on magnitudes; signs are restored once, in FIX.
    assign prod_mag = {part_q[B-1:0], low_q};
    assign prod_s   = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
    assign quo_s    = (neg_a_q ^ neg_b_q) ? -low_q : low_q;
    assign rem_s    = neg_a_q ? -part_q[B-1:0] : part_q[B-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        low_d   = low_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        is_div_d = is_div_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
`ifdef ALU_MULDIV_MADD_EN
        madd_d  = madd_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (op_s == OP_MTHI) begin
                        hi_d   = op1;
                        done_d = 1'b1;
                    end else if (op_s == OP_MTLO) begin
                        lo_d   = op1;
                        done_d = 1'b1;
                    end else if (is_mul_op || is_div_op) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        part_d   = '0;
                        low_d    = is_div_op ? a_mag : b_mag;
                        opnd_d   = is_div_op ? b_mag : a_mag;
                        is_div_d = is_div_op;
                        neg_a_d  = a_neg;
                        neg_b_d  = b_neg;
                        dz_d     = is_div_op && (op2 == '0);
`ifdef ALU_MULDIV_MADD_EN
                        madd_d   = is_madd_op;
`endif
                    end
                end
            end
            RUN: begin
                part_d = step_part;
                low_d  = is_div_q ? {low_q[B-2:0], step_bit} : {step_bit, low_q[B-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(B - 1)) begin
                    state_d = FIX;
                end
                if (flush) begin
                    state_d = IDLE;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Zero divisor: remainder magnitude is the dividend, so rem_s == op1.
                        hi_d  = rem_s;
                        lo_d  = dz_q ? '1 : quo_s;
                        dbz_d = dz_q;
                    end else begin
`ifdef ALU_MULDIV_MADD_EN
                        if (madd_q) begin
                            {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                        end else begin
                            {hi_d, lo_d} = prod_s;
                        end
`else
                        {hi_d, lo_d} = prod_s;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            part_q   <= '0;
            low_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef ALU_MULDIV_MADD_EN
            madd_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            part_q   <= part_d;
            low_q    <= low_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
`ifdef ALU_MULDIV_MADD_EN
            madd_q   <= madd_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed plan vectors, randomized ops
// against an arithmetic reference model, handshake, flush and reset scenarios.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int B = 32;

    logic         clk = 1'b0;
    logic         rst_n, start, flush;
    logic [2:0]   op;
    logic [B-1:0] op1, op2;
    logic         busy, done, div_by_zero;
    logic [B-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    logic [B-1:0] m_hi = '0;
    logic [B-1:0] m_lo = '0;
    bit   exp_done;
    logic exp_dbz;
    int   exp_lat;

    bit   obs_done;
    int   obs_lat;
    int   obs_busy;
    logic obs_dbz;

    always #5 clk = ~clk;

    alu_muldiv #(.B(B)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .op1         (op1),
        .op2         (op2),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // Architectural result of one operation, computed with plain 64-bit arithmetic.
    function automatic void ref_model(input logic [2:0] o, input logic [B-1:0] a,
                                      input logic [B-1:0] b, output bit e_done,
                                      output logic e_dbz, output int e_lat);
        longint sa, sb;
        logic [63:0] prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e_done = 1'b1;
        e_dbz  = 1'b0;
        e_lat  = B + 1;
        case (o)
            OP_MULT:  {m_hi, m_lo} = sa * sb;
            OP_MULTU: {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
            OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                    m_hi  = a;
                    m_lo  = '1;
                    e_dbz = 1'b1;
                end else if (o == OP_DIV) begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            OP_MTHI: begin m_hi = a; e_lat = 0; end
            OP_MTLO: begin m_lo = a; e_lat = 0; end
            default: begin
`ifdef ALU_MULDIV_MADD_EN
                prod = (o == OP_MADD) ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
                {m_hi, m_lo} = {m_hi, m_lo} + prod;
`else
                prod   = '0;
                e_done = 1'b0;
                e_lat  = 0;
`endif
            end
        endcase
    endfunction

    // Start one op, then observe until done or a bounded number of cycles.
    task automatic run_op(input logic [2:0] o, input logic [B-1:0] a, input logic [B-1:0] b);
        ref_model(o, a, b, exp_done, exp_dbz, exp_lat);
        @(negedge clk);
        start = 1'b1; op = o; op1 = a; op2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); op1 = $urandom; op2 = $urandom;
        obs_done = 1'b0; obs_lat = 0; obs_busy = 0; obs_dbz = 1'b0;
        for (int k = 0; k <= 3 * B; k++) begin
            if (busy) obs_busy++;
            if (done) begin
                obs_done = 1'b1; obs_lat = k; obs_dbz = div_by_zero;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; op1 = '0; op2 = '0;
        #12;
        checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
        checks++; if ({busy, done, div_by_zero} !== 3'b000) begin failures++; $display("FAIL reset_flags: got busy/done/dbz=%b want 000", {busy, done, div_by_zero}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    typedef struct packed {
        logic [2:0]   o;
        logic [B-1:0] a, b, eh, el;
        logic         dz;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[8];
        vecs = '{
            '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0},
            '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0},
            '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0},
            '{OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1},
            '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0},
            '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0},
            '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1},
            '{OP_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 1'b0}
        };
        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b);
            checks++; if (!obs_done || obs_lat != B + 1) begin failures++; $display("FAIL dir%0d_latency: got done=%0b lat=%0d want 1 %0d", i, obs_done, obs_lat, B + 1); end
            checks++; if (obs_busy != B + 1) begin failures++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, obs_busy, B + 1); end
            checks++; if (hi !== vecs[i].eh || lo !== vecs[i].el) begin failures++; $display("FAIL dir%0d_result: got %h_%h want %h_%h", i, hi, lo, vecs[i].eh, vecs[i].el); end
            checks++; if (obs_dbz !== vecs[i].dz) begin failures++; $display("FAIL dir%0d_dbz: got %b want %b", i, obs_dbz, vecs[i].dz); end
        end
    endtask

    function automatic logic [B-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h80000000;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0] o;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            run_op(o, pick(), pick());
            checks++; if (obs_done !== exp_done) begin failures++; $display("FAIL rnd%0d_done op=%0d: got %0b want %0b", i, o, obs_done, exp_done); end
            if (exp_done) begin
                checks++; if (obs_lat != exp_lat) begin failures++; $display("FAIL rnd%0d_latency op=%0d: got %0d want %0d", i, o, obs_lat, exp_lat); end
                checks++; if (obs_dbz !== exp_dbz) begin failures++; $display("FAIL rnd%0d_dbz op=%0d: got %b want %b", i, o, obs_dbz, exp_dbz); end
            end
            checks++; if (obs_busy != exp_lat) begin failures++; $display("FAIL rnd%0d_busy op=%0d: got %0d want %0d", i, o, obs_busy, exp_lat); end
            checks++; if (hi !== m_hi || lo !== m_lo) begin failures++; $display("FAIL rnd%0d_result op=%0d: got %h_%h want %h_%h", i, o, hi, lo, m_hi, m_lo); end
        end
    endtask

    task automatic test_mt_back_to_back();
        @(negedge clk); start = 1'b1; op = OP_MTHI; op1 = 32'h12345678;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || hi !== 32'h12345678) begin failures++; $display("FAIL mthi: got done=%b busy=%b hi=%h want 1 0 12345678", done, busy, hi); end
        op = OP_MTLO; op1 = 32'h9ABCDEF0;
        @(posedge clk); #1; start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || lo !== 32'h9ABCDEF0 || hi !== 32'h12345678) begin failures++; $display("FAIL mtlo: got done=%b busy=%b hi=%h lo=%h want 1 0 12345678 9abcdef0", done, busy, hi, lo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mt_quiet: got done=%b busy=%b want 0 0", done, busy); end
        m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
    endtask

    task automatic test_back_to_back();
        run_op(OP_MULTU, 32'd6, 32'd7);
        run_op(OP_DIVU, 32'd45, 32'd7);
        checks++; if (!obs_done || obs_lat != B + 1) begin failures++; $display("FAIL b2b_latency: got done=%0b lat=%0d want 1 %0d", obs_done, obs_lat, B + 1); end
        checks++; if (hi !== 32'd3 || lo !== 32'd6) begin failures++; $display("FAIL b2b_result: got %h_%h want 00000003_00000006", hi, lo); end
    endtask

    task automatic test_start_while_busy();
        bit seen;
        int lat;
        ref_model(OP_MULT, 32'd5, 32'd5, exp_done, exp_dbz, exp_lat);
        @(negedge clk); start = 1'b1; op = OP_MULT; op1 = 32'd5; op2 = 32'd5;
        @(posedge clk); #1; start = 1'b0; op1 = 32'd7;
        @(negedge clk); start = 1'b1; op = OP_MULTU; op2 = 32'd9;
        @(posedge clk); #1; start = 1'b0;
        seen = 1'b0; lat = 0;
        for (int k = 1; k <= 3 * B; k++) begin
            if (done) begin seen = 1'b1; lat = k; break; end
            @(posedge clk); #1;
        end
        checks++; if (!seen || lat != B + 1) begin failures++; $display("FAIL busy_start_latency: got done=%0b lat=%0d want 1 %0d", seen, lat, B + 1); end
        checks++; if (hi !== m_hi || lo !== m_lo) begin failures++; $display("FAIL busy_start_result: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
        seen = 1'b0;
        repeat (B + 4) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
        checks++; if (seen) begin failures++; $display("FAIL busy_start_requeued: got extra activity=1 want 0"); end
    endtask

    task automatic test_flush();
        bit seen;
        run_op(OP_MTHI, 32'hA5A50001, '0);
        run_op(OP_MTLO, 32'h5A5A0002, '0);
        @(negedge clk); start = 1'b1; op = OP_MULT; op1 = 32'd5; op2 = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL flush_run_idle: got busy=%b done=%b want 0 0", busy, done); end
        seen = 1'b0;
        repeat (B + 4) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        checks++; if (seen || hi !== m_hi || lo !== m_lo) begin failures++; $display("FAIL flush_run_keep: got done_seen=%0b %h_%h want 0 %h_%h", seen, hi, lo, m_hi, m_lo); end

        @(negedge clk); start = 1'b1; op = OP_MULTU; op1 = 32'd3; op2 = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (B) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_fix_busy: got %b want 1", busy); end
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin failures++; $display("FAIL flush_fix: got busy=%b done=%b %h_%h want 0 0 %h_%h", busy, done, hi, lo, m_hi, m_lo); end

        @(negedge clk); start = 1'b1; flush = 1'b1; op = OP_MTHI; op1 = 32'hCAFEF00D;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi) begin failures++; $display("FAIL flush_idle_start: got busy=%b done=%b hi=%h want 0 0 %h", busy, done, hi, m_hi); end
    endtask

    task automatic test_reset_mid();
        run_op(OP_MTHI, 32'hDEADBEEF, '0);
        @(negedge clk); start = 1'b1; op = OP_DIV; op1 = $urandom; op2 = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        checks++; if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_mid: got busy=%b done=%b %h_%h want 0 0 0_0", busy, done, hi, lo); end
        m_hi = '0; m_lo = '0;
        @(negedge clk); rst_n = 1'b1;
        run_op(OP_MULTU, 32'd3, 32'd4);
        checks++; if (!obs_done || obs_lat != B + 1 || lo !== 32'd12 || hi !== '0) begin failures++; $display("FAIL reset_recover: got done=%0b lat=%0d %h_%h want 1 %0d 0_c", obs_done, obs_lat, hi, lo, B + 1); end
    endtask

    task automatic test_madd();
        run_op(OP_MTHI, '0, '0);
        run_op(OP_MTLO, '1, '0);
        run_op(OP_MADDU, 32'd1, 32'd1);
`ifdef ALU_MULDIV_MADD_EN
        checks++; if (!obs_done || obs_lat != B + 1) begin failures++; $display("FAIL maddu_latency: got done=%0b lat=%0d want 1 %0d", obs_done, obs_lat, B + 1); end
        checks++; if (hi !== 32'd1 || lo !== '0) begin failures++; $display("FAIL maddu_result: got %h_%h want 00000001_00000000", hi, lo); end
        run_op(OP_MADD, 32'hFFFFFFFF, 32'd1);
        checks++; if (hi !== '0 || lo !== '1) begin failures++; $display("FAIL madd_result: got %h_%h want 00000000_ffffffff", hi, lo); end
`else
        checks++; if (obs_done || obs_busy != 0) begin failures++; $display("FAIL maddu_nop: got done=%0b busy_cycles=%0d want 0 0", obs_done, obs_busy); end
        checks++; if (hi !== '0 || lo !== '1) begin failures++; $display("FAIL maddu_nop_keep: got %h_%h want 00000000_ffffffff", hi, lo); end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mt_back_to_back();
        test_back_to_back();
        test_start_while_busy();
        test_flush();
        test_reset_mid();
        test_madd();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the combinational execute-stage ALU and handles MULT, MULTU, DIV, DIVU, MTHI and MTLO. Operations are started with a start/busy/done handshake; the execute stage stalls on busy. Width is parametrised, and an optional multiply-accumulate mode is available.

Parameters:
B, 32, operand/HI/LO width; must be even and at least 4.
CNT_W, $clog2(B)+1, iteration counter width (derived; not overridden).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
op  in  3  operation code (see package).
op1  in  B  rs operand (multiplicand/dividend; MTHI/MTLO source).
op2  in  B  rt operand (multiplier/divisor).
flush  in  1  cancel the in-flight operation (pipeline flush).
busy  out  1  high whenever state != IDLE; combinational from state.
done  out  1  one-cycle registered pulse; HI/LO are valid in the same cycle.
div_by_zero  out  1  registered; pulses together with done for DIV/DIVU with op2==0.
hi  out  B  HI register.
lo  out  B  LO register.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, hi=0, lo=0, done=0, div_by_zero=0, counter=0.
- Op codes:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 MADD, 111 MADDU (macro only). Without the macro these are NOPs: no state change, no done.
- States: IDLE -> RUN -> FIX -> IDLE.
- Start edge E0 (IDLE, start=1):
  - Mul/div ops: latch operand magnitudes and sign flags, counter=0, go to RUN.
  - MTHI/MTLO: write hi/lo at E0, stay IDLE, done=1 for the cycle after E0.
- RUN: one radix-2 step per cycle (shift-add multiply; restoring divide). Exactly B cycles, then FIX.
- FIX: apply sign correction, write hi/lo, assert done (and div_by_zero if applicable), return to IDLE.
  - Update edge is E0+B+1; done is high in the cycle after it.
  - busy is high from after E0 until the edge E0+B+1.
- Result rules:
  - MULT/MULTU: full 2B-bit product; hi=upper B bits, lo=lower B bits.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Quotient goes to lo, remainder to hi.
- Boundary conditions:
  - Divide by zero (op2==0, DIV or DIVU): full latency still applies; lo=all ones, hi=op1 (unchanged dividend), div_by_zero=1.
  - Signed overflow, most-negative / -1: lo=most-negative (two's-complement wrap), hi=0, no flag.
  - start while busy: ignored; operands are not resampled.
  - start coincident with done cycle: accepted (state is IDLE).
  - flush in RUN or FIX: next edge returns to IDLE. hi/lo unchanged, no done. Flush has priority over the FIX write.
  - flush with start in IDLE: start is ignored.
  - rst_n low mid-operation: immediate return to reset values.
- Operands are captured at E0. Later changes to op1/op2 have no effect.

Optional Feature:
ALU_MULDIV_MADD_EN
- Defined: op 110/111 perform {hi,lo} <= {hi,lo} + product (signed/unsigned), modulo 2^(2B). Accumulation happens in FIX, with the same latency as MULT.
- Undefined: 110/111 are ignored as NOPs and no accumulate adder is synthesised.

Decomposition:
- Package alu_muldiv_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU.
  - state typedef: IDLE, RUN, FIX.
- Sub-module muldiv_step: combinational single radix-2 iteration. Inputs are mode, partial remainder/product, and operand. Outputs are next partial and next quotient bit. Instantiated once in alu_muldiv.

Test Plan:
1. MULT op1=0xFFFFFFFD(-3), op2=7 -> done at start+33 edges; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
2. MULTU op1=op2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then DIV op1=0xFFFFFFF9(-7), op2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU op1=100, op2=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 with done. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
4. MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> each done one cycle after its start; hi and lo hold the written values; busy never asserted.
5. MULT 5*5 started, flush at 10th RUN cycle -> IDLE next edge, hi/lo keep prior values, no done. A start with new op2 asserted during RUN is ignored. rst_n low mid-RUN -> hi=lo=0 immediately.
6. With ALU_MULDIV_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0. Without the macro, same stimulus -> no done, hi/lo unchanged.
